// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: redirect to fetch, flush window, link value and perf counters.
// Outputs registered (1-cycle latency); redirect held until redirect_ready; execute stalled while not IDLE.
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1,
    input  logic             ex_pred_taken,
    input  logic             cmp_res,
    output logic             ex_stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             flush,
    output logic             link_valid,
    output logic [31:0]      link_val,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             link_valid_q, link_valid_d;
    logic [31:0]      link_val_q, link_val_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic        is_link, accept, taken, misalign, mispredict;
    logic [31:0] target, next_pc, pc_plus4;

    // JAL/JALR are always taken, which also gives them priority over the branch flag.
    always_comb begin
        is_link    = ex_is_jal | ex_is_jalr;
        accept     = ex_valid & (ex_is_branch | is_link) & (state_q == S_IDLE);
        taken      = is_link | (ex_is_branch & cmp_res);
        pc_plus4   = ex_pc + 32'd4;
        target     = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
        next_pc    = taken ? target : pc_plus4;
        misalign   = taken & target[1];
        mispredict = taken ^ ex_pred_taken;
    end

    always_comb begin
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        link_valid_d     = accept & is_link & ~misalign;
        link_val_d       = link_val_q;
        misalign_d       = accept & misalign;
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;

        if (link_valid_d) begin
            link_val_d = pc_plus4;
        end
        if (accept && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept && !misalign && mispredict) begin
                    state_d          = S_REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = next_pc;
                    if (!(&mispred_cnt_q)) begin
                        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_REDIRECT: begin
                if (redirect_valid_q && redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    if (FLUSH_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        fcnt_d  = FLUSH_LOAD;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            fcnt_q           <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            link_valid_q     <= 1'b0;
            link_val_q       <= 32'd0;
            misalign_q       <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            link_valid_q     <= link_valid_d;
            link_val_q       <= link_val_d;
            misalign_q       <= misalign_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign ex_stall       = (state_q != S_IDLE);
    assign flush          = (state_q == S_REDIRECT) || (state_q == S_FLUSH);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign link_valid     = link_valid_q;
    assign link_val       = link_val_q;
    assign misalign_exc   = misalign_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;
endmodule
